// File: rtl/usb_encoder.sv
// USB 2.0 HS packet encoder: handshake, token and data packets (PID + CRC16) onto one AXI4-Stream byte path.
// Optional simulation-only protocol checks are enabled with `define ENCODER_SIM_CHECKS_EN.
module usb_encoder #(
  parameter int unsigned TOKEN = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        enc_busy_o,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  output logic        tx_tlast_o,
  output logic [7:0]  tx_tdata_o,
  input  logic        hsk_send_i,
  input  logic [1:0]  hsk_type_i,
  output logic        hsk_done_o,
  input  logic        tok_send_i,
  input  logic [1:0]  tok_type_i,
  input  logic [15:0] tok_data_i,
  output logic        tok_done_o,
  input  logic        trn_tsend_i,
  input  logic [1:0]  trn_ttype_i,
  output logic        trn_tdone_o,
  input  logic        trn_tvalid_i,
  output logic        trn_tready_o,
  input  logic        trn_tlast_i,
  input  logic [7:0]  trn_tdata_i
);

  localparam bit              TOK_EN   = (TOKEN != 0);
  localparam logic [1:0]      KIND_TOK = 2'b01;
  localparam logic [1:0]      KIND_HSK = 2'b10;
  localparam logic [1:0]      KIND_DAT = 2'b11;
  localparam logic [15:0]     CRC_INIT = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE, S_HSK, S_TOK1, S_TOK2, S_TOK3, S_DPID, S_DATA, S_CRC1, S_CRC2
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_pid;
  logic [15:0] r_tok;
  logic [15:0] r_crc;
  logic        r_zlp;
  logic        r_hsk_arm, r_tok_arm, r_trn_arm;
  logic        r_hsk_done, r_tok_done, r_trn_done;

  logic        w_hsk_req, w_tok_req, w_trn_req;
  logic        w_hsk_acc, w_tok_acc, w_trn_acc;
  logic        w_fin, w_crc_upd;
  logic        w_tx_valid, w_tx_last, w_trn_ready;
  logic [7:0]  w_tx_data;

  function automatic logic [7:0] pid_byte(input logic [1:0] t, input logic [1:0] k);
    logic [3:0] p;
    p = {t, k};
    return {~p, p};
  endfunction

  // Reflected CRC16 (poly 0x8005 -> 0xA001), one payload byte, LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
    end
    return x;
  endfunction

  // A request level must be seen low once after acceptance before it can be taken again
  assign w_hsk_req = hsk_send_i & r_hsk_arm;
  assign w_tok_req = TOK_EN & tok_send_i & r_tok_arm;
  assign w_trn_req = trn_tsend_i & r_trn_arm;

  always_comb begin
    w_next      = r_state;
    w_tx_valid  = 1'b0;
    w_tx_last   = 1'b0;
    w_tx_data   = 8'h00;
    w_trn_ready = 1'b0;
    w_hsk_acc   = 1'b0;
    w_tok_acc   = 1'b0;
    w_trn_acc   = 1'b0;
    w_fin       = 1'b0;
    w_crc_upd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hsk_req) begin
          w_hsk_acc = 1'b1;
          w_next    = S_HSK;
        end else if (w_tok_req) begin
          w_tok_acc = 1'b1;
          w_next    = S_TOK1;
        end else if (w_trn_req) begin
          w_trn_acc = 1'b1;
          w_next    = S_DPID;
        end
      end
      S_HSK: begin
        w_tx_valid = 1'b1;
        w_tx_last  = 1'b1;
        w_tx_data  = r_pid;
        if (tx_tready_i) begin
          w_fin  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_TOK1: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_pid;
        if (tx_tready_i) w_next = S_TOK2;
      end
      S_TOK2: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_tok[7:0];
        if (tx_tready_i) w_next = S_TOK3;
      end
      S_TOK3: begin
        w_tx_valid = 1'b1;
        w_tx_last  = 1'b1;
        w_tx_data  = r_tok[15:8];
        if (tx_tready_i) begin
          w_fin  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_DPID: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_pid;
        if (tx_tready_i) w_next = r_zlp ? S_CRC1 : S_DATA;
      end
      S_DATA: begin
        w_tx_valid  = trn_tvalid_i;
        w_tx_data   = trn_tdata_i;
        w_trn_ready = tx_tready_i;
        if (trn_tvalid_i && tx_tready_i) begin
          w_crc_upd = 1'b1;
          if (trn_tlast_i) w_next = S_CRC1;
        end
      end
      S_CRC1: begin
        w_tx_valid = 1'b1;
        w_tx_data  = ~r_crc[7:0];
        if (tx_tready_i) w_next = S_CRC2;
      end
      S_CRC2: begin
        w_tx_valid = 1'b1;
        w_tx_last  = 1'b1;
        w_tx_data  = ~r_crc[15:8];
        if (tx_tready_i) begin
          w_fin  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pid      <= 8'h00;
      r_tok      <= 16'h0000;
      r_crc      <= CRC_INIT;
      r_zlp      <= 1'b0;
      r_hsk_arm  <= 1'b1;
      r_tok_arm  <= 1'b1;
      r_trn_arm  <= 1'b1;
      r_hsk_done <= 1'b0;
      r_tok_done <= 1'b0;
      r_trn_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hsk_acc) r_pid <= pid_byte(hsk_type_i, KIND_HSK);
      if (w_tok_acc) begin
        r_pid <= pid_byte(tok_type_i, KIND_TOK);
        r_tok <= tok_data_i;
      end
      if (w_trn_acc) begin
        r_pid <= pid_byte(trn_ttype_i, KIND_DAT);
        r_crc <= CRC_INIT;
        r_zlp <= trn_tlast_i & ~trn_tvalid_i;
      end else if (w_crc_upd) begin
        r_crc <= crc16_byte(r_crc, trn_tdata_i);
      end
      r_hsk_arm  <= w_hsk_acc ? 1'b0 : (r_hsk_arm | ~hsk_send_i);
      r_tok_arm  <= w_tok_acc ? 1'b0 : (r_tok_arm | ~tok_send_i);
      r_trn_arm  <= w_trn_acc ? 1'b0 : (r_trn_arm | ~trn_tsend_i);
      r_hsk_done <= w_fin && (r_state == S_HSK);
      r_tok_done <= w_fin && (r_state == S_TOK3);
      r_trn_done <= w_fin && (r_state == S_CRC2);
    end
  end

  assign enc_busy_o   = (r_state != S_IDLE);
  assign tx_tvalid_o  = w_tx_valid;
  assign tx_tlast_o   = w_tx_last;
  assign tx_tdata_o   = w_tx_data;
  assign trn_tready_o = w_trn_ready;
  assign hsk_done_o   = r_hsk_done;
  assign tok_done_o   = r_tok_done;
  assign trn_tdone_o  = r_trn_done;

`ifdef ENCODER_SIM_CHECKS_EN
  logic       r_p_hsk, r_p_tok, r_p_trn, r_p_stall;
  logic [1:0] r_p_htype, r_p_ttype, r_p_dtype;
  logic [7:0] r_p_data;

  // Requester and stream protocol monitors; no effect on the datapath
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_p_hsk   <= 1'b0;
      r_p_tok   <= 1'b0;
      r_p_trn   <= 1'b0;
      r_p_stall <= 1'b0;
      r_p_htype <= 2'b00;
      r_p_ttype <= 2'b00;
      r_p_dtype <= 2'b00;
      r_p_data  <= 8'h00;
    end else begin
      if (enc_busy_o && hsk_send_i && !r_p_hsk && r_state != S_HSK)
        $error("usb_encoder: handshake request while busy with another packet");
      if (enc_busy_o && tok_send_i && !r_p_tok && !(r_state inside {S_TOK1, S_TOK2, S_TOK3}))
        $error("usb_encoder: token request while busy with another packet");
      if (enc_busy_o && trn_tsend_i && !r_p_trn && !(r_state inside {S_DPID, S_DATA, S_CRC1, S_CRC2}))
        $error("usb_encoder: data request while busy with another packet");
      if (hsk_send_i && r_p_hsk && hsk_type_i != r_p_htype)
        $error("usb_encoder: hsk_type_i changed while pending");
      if (tok_send_i && r_p_tok && tok_type_i != r_p_ttype)
        $error("usb_encoder: tok_type_i changed while pending");
      if (trn_tsend_i && r_p_trn && trn_ttype_i != r_p_dtype)
        $error("usb_encoder: trn_ttype_i changed while pending");
      if (r_p_stall && tx_tvalid_o && tx_tdata_o != r_p_data)
        $error("usb_encoder: tx_tdata_o changed while stalled");
      r_p_hsk   <= hsk_send_i;
      r_p_tok   <= tok_send_i;
      r_p_trn   <= trn_tsend_i;
      r_p_htype <= hsk_type_i;
      r_p_ttype <= tok_type_i;
      r_p_dtype <= trn_ttype_i;
      r_p_stall <= tx_tvalid_o & ~tx_tready_i;
      r_p_data  <= tx_tdata_o;
    end
  end
`endif

endmodule

// File: tb/tb_usb_encoder.sv
// Randomized bench for usb_encoder: expected byte stream and done pulses come from a packet-level model.
module tb_usb_encoder;

  logic        clock;
  logic        reset_n;
  logic        enc_busy_o;
  logic        tx_tvalid_o;
  logic        tx_tready_i;
  logic        tx_tlast_o;
  logic [7:0]  tx_tdata_o;
  logic        hsk_send_i;
  logic [1:0]  hsk_type_i;
  logic        hsk_done_o;
  logic        tok_send_i;
  logic [1:0]  tok_type_i;
  logic [15:0] tok_data_i;
  logic        tok_done_o;
  logic        trn_tsend_i;
  logic [1:0]  trn_ttype_i;
  logic        trn_tdone_o;
  logic        trn_tvalid_i;
  logic        trn_tready_o;
  logic        trn_tlast_i;
  logic [7:0]  trn_tdata_i;

  usb_encoder #(.TOKEN(1)) dut (
    .clock(clock), .reset_n(reset_n), .enc_busy_o(enc_busy_o),
    .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i), .tx_tlast_o(tx_tlast_o),
    .tx_tdata_o(tx_tdata_o), .hsk_send_i(hsk_send_i), .hsk_type_i(hsk_type_i),
    .hsk_done_o(hsk_done_o), .tok_send_i(tok_send_i), .tok_type_i(tok_type_i),
    .tok_data_i(tok_data_i), .tok_done_o(tok_done_o), .trn_tsend_i(trn_tsend_i),
    .trn_ttype_i(trn_ttype_i), .trn_tdone_o(trn_tdone_o), .trn_tvalid_i(trn_tvalid_i),
    .trn_tready_o(trn_tready_o), .trn_tlast_i(trn_tlast_i), .trn_tdata_i(trn_tdata_i)
  );

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;           // 0: PHY always ready, 1: random back-pressure
  logic [10:0] exp_q[$];        // {done index, last, byte}
  logic [7:0]  pay_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_tready_i = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tx_tready_i = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 55);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Model: PID nibble = type*4 + kind, byte = {~nibble, nibble}
  function automatic logic [7:0] m_pid(input int kind, input logic [1:0] t);
    int p;
    p = int'(t) * 4 + kind;
    return 8'(((15 - p) << 4) | p);
  endfunction

  // Model CRC16: MSB-first register over bits in wire order, reflected at the end
  function automatic logic [15:0] m_crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
    end
    return r;
  endfunction

  function automatic logic [15:0] m_crc_payload();
    logic [15:0] c, rv;
    c = 16'hFFFF;
    foreach (pay_q[i]) c = m_crc_step(c, pay_q[i]);
    for (int i = 0; i < 16; i++) rv[i] = c[15 - i];
    return ~rv;
  endfunction

  task automatic push(input logic [1:0] di, input logic last, input logic [7:0] d);
    exp_q.push_back({di, last, d});
  endtask

  // Per-cycle compare against the expected stream, done pulses and AXI-S hold rule
  logic [2:0]  pend, pend_n, got_done;
  logic        prev_stall;
  logic [8:0]  prev_word;
  logic [10:0] e;

  always @(negedge clock) begin
    if (!reset_n) begin
      pend       = 3'b000;
      prev_stall = 1'b0;
    end else begin
      got_done = {trn_tdone_o, tok_done_o, hsk_done_o};
      if (got_done != 3'b000 || pend != 3'b000) chk("done_pulse", 32'(got_done), 32'(pend));
      pend_n = 3'b000;
      if (prev_stall) chk("stall_hold", 32'({tx_tvalid_o, tx_tlast_o, tx_tdata_o}), 32'({1'b1, prev_word}));
      if (tx_tvalid_o && tx_tready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", {tx_tlast_o, tx_tdata_o});
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'({tx_tlast_o, tx_tdata_o}), 32'(e[8:0]));
          if (e[8]) pend_n = 3'(1 << e[10:9]);
        end
      end
      prev_stall = tx_tvalid_o && !tx_tready_i;
      prev_word  = {tx_tlast_o, tx_tdata_o};
      pend       = pend_n;
    end
  end

  task automatic wait_done(input int which);
    logic seen;
    int   cyc;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      seen = (which == 0) ? hsk_done_o : (which == 1) ? tok_done_o : trn_tdone_o;
      @(posedge clock);
      #1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got none expected done index %0d", which);
    end
  endtask

  task automatic send_hsk(input logic [1:0] t, input int extra);
    push(2'd0, 1'b1, m_pid(2, t));
    hsk_send_i = 1'b1;
    hsk_type_i = t;
    wait_done(0);
    repeat (extra) begin
      @(posedge clock);
      #1;
    end
    hsk_send_i = 1'b0;
  endtask

  task automatic send_tok(input logic [1:0] t, input logic [15:0] d);
    push(2'd1, 1'b0, m_pid(1, t));
    push(2'd1, 1'b0, d[7:0]);
    push(2'd1, 1'b1, d[15:8]);
    tok_send_i = 1'b1;
    tok_type_i = t;
    tok_data_i = d;
    wait_done(1);
    tok_send_i = 1'b0;
  endtask

  // Sends pay_q as a data packet; the source inserts random idle gaps
  task automatic send_data(input logic [1:0] t);
    int n, idx, cyc;
    logic done_seen, adv, busy_now;
    logic [15:0] crc;
    n   = pay_q.size();
    crc = m_crc_payload();
    push(2'd2, 1'b0, m_pid(3, t));
    foreach (pay_q[i]) push(2'd2, 1'b0, pay_q[i]);
    push(2'd2, 1'b0, crc[7:0]);
    push(2'd2, 1'b1, crc[15:8]);
    trn_tsend_i = 1'b1;
    trn_ttype_i = t;
    if (n == 0) begin
      trn_tvalid_i = 1'b0;
      trn_tlast_i  = 1'b1;
    end else begin
      trn_tvalid_i = 1'b1;
      trn_tdata_i  = pay_q[0];
      trn_tlast_i  = (n == 1);
    end
    idx = 0;
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      done_seen = trn_tdone_o;
      adv       = trn_tvalid_i && trn_tready_o;
      busy_now  = enc_busy_o;
      @(posedge clock);
      #1;
      if (busy_now) begin
        trn_tsend_i = 1'b0;
        if (n == 0) trn_tlast_i = 1'b0;
      end
      if (n > 0) begin
        if (adv) idx++;
        if (adv || !trn_tvalid_i) begin
          if (idx < n && $urandom_range(0, 3) != 0) begin
            trn_tvalid_i = 1'b1;
            trn_tdata_i  = pay_q[idx];
            trn_tlast_i  = (idx == n - 1);
          end else begin
            trn_tvalid_i = 1'b0;
            trn_tlast_i  = 1'b0;
          end
        end
      end
    end
    trn_tsend_i  = 1'b0;
    trn_tvalid_i = 1'b0;
    trn_tlast_i  = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL data_timeout: got none expected trn_tdone_o");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int k, len;
    reset_n = 1'b0;
    hsk_send_i = 1'b0; hsk_type_i = 2'b00;
    tok_send_i = 1'b0; tok_type_i = 2'b00; tok_data_i = 16'h0000;
    trn_tsend_i = 1'b0; trn_ttype_i = 2'b00;
    trn_tvalid_i = 1'b0; trn_tlast_i = 1'b0; trn_tdata_i = 8'h00;

    // Pin the model with hand-computed values
    chk("pin_pid_ack",   32'(m_pid(2, 2'b00)), 32'hD2);
    chk("pin_pid_nak",   32'(m_pid(2, 2'b10)), 32'h5A);
    chk("pin_pid_setup", 32'(m_pid(1, 2'b11)), 32'h2D);
    chk("pin_pid_in",    32'(m_pid(1, 2'b10)), 32'h69);
    chk("pin_pid_data0", 32'(m_pid(3, 2'b00)), 32'hC3);
    chk("pin_pid_data1", 32'(m_pid(3, 2'b10)), 32'h4B);
    pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("pin_crc16_check", 32'(m_crc_payload()), 32'hB4C8);
    pay_q.delete();
    chk("pin_crc16_empty", 32'(m_crc_payload()), 32'h0000);

    idle(3);
    @(negedge clock);
    chk("rst_outputs", 32'({tx_tvalid_o, tx_tlast_o, tx_tdata_o, enc_busy_o, trn_tready_o}), 32'h0);
    chk("rst_done", 32'({hsk_done_o, tok_done_o, trn_tdone_o}), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Directed cases
    send_hsk(2'b00, 0);
    idle(2);
    send_hsk(2'b10, 0);
    idle(2);
    send_tok(2'b11, 16'h1000);
    idle(2);
    send_tok(2'b10, 16'hE009);
    idle(2);
    pay_q = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    send_data(2'b00);
    idle(2);
    pay_q.delete();
    send_data(2'b10);
    idle(2);

    // Simultaneous handshake and token: handshake first
    push(2'd0, 1'b1, m_pid(2, 2'b11));
    push(2'd1, 1'b0, m_pid(1, 2'b00));
    push(2'd1, 1'b0, 8'h85);
    push(2'd1, 1'b1, 8'h3A);
    hsk_send_i = 1'b1; hsk_type_i = 2'b11;
    tok_send_i = 1'b1; tok_type_i = 2'b00; tok_data_i = 16'h3A85;
    wait_done(0);
    hsk_send_i = 1'b0;
    wait_done(1);
    tok_send_i = 1'b0;
    idle(2);

    // Request left high one cycle past done must not repeat
    send_hsk(2'b01, 1);
    idle(5);
    @(negedge clock);
    chk("no_dup_busy", 32'(enc_busy_o), 32'h0);
    chk("no_dup_queue", 32'(exp_q.size()), 32'h0);
    idle(1);

    // Random packets with random back-pressure
    for (int it = 0; it < 40; it++) begin
      ready_mode = (it < 4) ? 0 : int'($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 2);
      if (k == 0) begin
        send_hsk(2'($urandom_range(0, 3)), 0);
      end else if (k == 1) begin
        send_tok(2'($urandom_range(0, 3)), 16'($urandom));
      end else begin
        len = $urandom_range(0, 16);
        pay_q.delete();
        for (int j = 0; j < len; j++) pay_q.push_back(8'($urandom));
        send_data(2'($urandom_range(0, 3)));
      end
      idle($urandom_range(0, 3));
    end
    ready_mode = 0;
    idle(3);

    // Reset in the middle of a token: abort with no tlast and no done
    tok_send_i = 1'b1; tok_type_i = 2'b10; tok_data_i = 16'h4321;
    push(2'd1, 1'b0, m_pid(1, 2'b10));
    k = 0;
    do begin
      @(negedge clock);
      k++;
      len = int'(enc_busy_o);
      @(posedge clock);
      #1;
    end while (len == 0 && k < 50);
    chk("midtok_busy", 32'(len), 32'h1);
    exp_q.delete();
    reset_n    = 1'b0;
    tok_send_i = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("midtok_rst_valid", 32'({tx_tvalid_o, tx_tlast_o, enc_busy_o}), 32'h0);
    chk("midtok_rst_done", 32'(tok_done_o), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(3);
    @(negedge clock);
    chk("post_rst_idle", 32'({tx_tvalid_o, enc_busy_o, tok_done_o}), 32'h0);
    idle(1);
    send_hsk(2'b00, 0);
    idle(4);
    chk("end_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
